// File: rtl/sbtm_pkg.sv
// sbtm_pkg: shared widths, table contents and field helpers for the
// symmetric bipartite table method evaluator.
package sbtm_pkg;

  localparam int X0_W      = 3;
  localparam int X1_W      = 2;
  localparam int X2_W      = 2;
  localparam int A0_W      = 8;
  localparam int A1_W      = 3;
  localparam int X_W       = X0_W + X1_W + X2_W;
  localparam int A0_ADDR_W = X0_W + X1_W;
  localparam int A1_ADDR_W = X0_W + X2_W - 1;
  localparam int A0_DEPTH  = 1 << A0_ADDR_W;
  localparam int A1_DEPTH  = 1 << A1_ADDR_W;

  // Folded a1 address together with the symmetry sign taken from x2.
  typedef struct packed {
    logic                 s;
    logic [A1_ADDR_W-1:0] addr;
  } addr1_t;

  // Initial-value table a0: entry i holds 8*i.
  localparam logic [A0_W-1:0] A0_TABLE [A0_DEPTH] = '{
    8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
    8'h40, 8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78,
    8'h80, 8'h88, 8'h90, 8'h98, 8'hA0, 8'hA8, 8'hB0, 8'hB8,
    8'hC0, 8'hC8, 8'hD0, 8'hD8, 8'hE0, 8'hE8, 8'hF0, 8'hF8
  };

  // Offset-magnitude table a1: entry j holds j truncated to A1_W bits.
  localparam logic [A1_W-1:0] A1_TABLE [A1_DEPTH] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
  };

  // The lower half of x2 mirrors the upper half, so when the sign bit is
  // set the remaining bits are inverted to reuse the same a1 entry.
  function automatic addr1_t fold_addr1(input logic [X0_W-1:0] x0,
                                        input logic [X2_W-1:0] x2);
    addr1_t           r;
    logic [X2_W-2:0]  lo;
    lo     = x2[X2_W-2:0];
    r.s    = x2[X2_W-1];
    r.addr = {x0, (r.s ? ~lo : lo)};
    return r;
  endfunction

  // One's-complement negation of the magnitude when s=1, then sign-extend
  // the (A1_W+1)-bit two's-complement value to the result width.
  function automatic logic [A0_W-1:0] offset_ext(input logic [A1_W-1:0] d1,
                                                 input logic            s);
    logic [A1_W:0] off;
    off = {s, d1 ^ {A1_W{s}}};
    return {{(A0_W-A1_W-1){s}}, off};
  endfunction

endpackage

// File: rtl/sbtm_pipe_ctl.sv
// sbtm_pipe_ctl: 3-entry valid/ready shift controller. A stage may advance
// when it is empty or the stage after it advances; load_k is the actual
// capture enable (advance and upstream data present).
module sbtm_pipe_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load1,
  output logic load2,
  output logic load3
);

  logic [2:0] v_q, v_d;
  logic       adv1, adv2, adv3;

  // Advance chain from the output back to the input, then next valid bits.
  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    adv3   = ~v_q[2] | out_ready;
    adv2   = ~v_q[1] | adv3;
    adv1   = ~v_q[0] | adv2;
    load1  = adv1 & in_valid;
    load2  = adv2 & v_q[0];
    load3  = adv3 & v_q[1];
    v_d    = v_q;
    if (adv1) v_d[0] = in_valid;
    if (adv2) v_d[1] = v_q[0];
    if (adv3) v_d[2] = v_q[1];
  end

  // Valid-bit state; cleared asynchronously so in-flight items are dropped.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  assign in_ready  = adv1;
  assign out_valid = v_q[2];

endmodule

// File: rtl/sbtm_roms.sv
// rom_a0 / rom_a1: combinational constant lookup tables feeding the
// evaluator; address to data within the same cycle.
module rom_a0
  import sbtm_pkg::*;
(
  input  logic [A0_ADDR_W-1:0] addr,
  output logic [A0_W-1:0]      data
);
  // NOTE: a constant table has no state, so there is nothing to reset;
  // only the pipeline registers downstream carry a reset.
  assign data = A0_TABLE[addr];
endmodule

module rom_a1
  import sbtm_pkg::*;
(
  input  logic [A1_ADDR_W-1:0] addr,
  output logic [A1_W-1:0]      data
);
  assign data = A1_TABLE[addr];
endmodule

// File: rtl/sbtm_eval_pipe.sv
// sbtm_eval_pipe: 3-stage SBTM evaluator. S1 splits x and forms both ROM
// addresses, S2 registers the ROM data, S3 adds initial value and offset.
// Build option: define SBTM_SAT_EN to clamp the S3 sum to 0..2^A0_W-1
// instead of wrapping modulo 2^A0_W.
module sbtm_eval_pipe
  import sbtm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [X_W-1:0]  x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [A0_W-1:0] y
);

  logic load1, load2, load3;

  sbtm_pipe_ctl u_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .load1     (load1),
    .load2     (load2),
    .load3     (load3)
  );

  logic [X0_W-1:0]      x0;
  logic [X1_W-1:0]      x1;
  logic [X2_W-1:0]      x2;
  addr1_t               fold;

  logic [A0_ADDR_W-1:0] addr0_q, addr0_d;
  logic [A1_ADDR_W-1:0] addr1_q, addr1_d;
  logic                 s1_q, s1_d;
  logic [A0_W-1:0]      d0_q, d0_d;
  logic [A1_W-1:0]      d1_q, d1_d;
  logic                 s2_q, s2_d;
  logic [A0_W-1:0]      y_q, y_d;

  logic [A0_W-1:0]      rom0_data;
  logic [A1_W-1:0]      rom1_data;
  logic [A0_W-1:0]      offset;

  rom_a0 u_rom_a0 (.addr(addr0_q), .data(rom0_data));
  rom_a1 u_rom_a1 (.addr(addr1_q), .data(rom1_data));

  assign x0     = x[X_W-1 -: X0_W];
  assign x1     = x[X2_W +: X1_W];
  assign x2     = x[X2_W-1:0];
  assign fold   = fold_addr1(x0, x2);
  assign offset = offset_ext(d1_q, s2_q);

  // S1/S2 next-state: capture only on load so an undriven x while
  // in_valid=0 never enters the pipe.
  always_comb begin
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    s1_d    = s1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    s2_d    = s2_q;
    if (load1) begin
      addr0_d = {x0, x1};
      addr1_d = fold.addr;
      s1_d    = fold.s;
    end
    if (load2) begin
      d0_d = rom0_data;
      d1_d = rom1_data;
      s2_d = s1_q;
    end
  end

`ifdef SBTM_SAT_EN
  logic [A0_W+1:0] sum_wide;

  // S3 next-state with clamping: two extra bits hold sign and carry.
  always_comb begin
    sum_wide = {2'b00, d0_q} + {{2{offset[A0_W-1]}}, offset};
    y_d      = y_q;
    if (load3) begin
      if (sum_wide[A0_W+1])    y_d = '0;
      else if (sum_wide[A0_W]) y_d = '1;
      else                     y_d = sum_wide[A0_W-1:0];
    end
  end
`else
  // S3 next-state with modulo-2^A0_W wrap.
  always_comb begin
    y_d = y_q;
    if (load3) y_d = d0_q + offset;
  end
`endif

  // Pipeline data registers, all cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr0_q <= '0;
      addr1_q <= '0;
      s1_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      s2_q    <= 1'b0;
      y_q     <= '0;
    end else begin
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      s1_q    <= s1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      s2_q    <= s2_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_sbtm_eval_pipe.sv
// tb_sbtm_eval_pipe: directed vectors with hand-computed results plus an
// in-order scoreboard fed by an independent arithmetic model.
module tb_sbtm_eval_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;

  int vectors     = 0;
  int miscompares = 0;
  int in_count    = 0;
  int out_count   = 0;
  logic [7:0] exp_q [$];

  sbtm_eval_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a0[i]=8*i, a1[j]=j mod 8, offset = d1 or -(d1+1).
  function automatic logic [7:0] model(input logic [6:0] xv);
    int a0v, j, d1, off, sum;
    logic s, lo;
    a0v = 8 * int'(xv[6:2]);
    s   = xv[1];
    lo  = s ? ~xv[0] : xv[0];
    j   = int'(xv[6:4]) * 2 + int'(lo);
    d1  = j % 8;
    off = s ? -(d1 + 1) : d1;
    sum = a0v + off;
`ifdef SBTM_SAT_EN
    if (sum < 0)   sum = 0;
    if (sum > 255) sum = 255;
`endif
    return 8'(sum & 255);
  endfunction

  // Scoreboard: transfers are sampled mid-cycle, ahead of the edge that
  // completes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(y), 32'hDEAD);
        else                   check("stream_y", 32'(y), 32'(exp_q.pop_front()));
        out_count++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x));
        in_count++;
      end
    end
  end

  // Single item into an empty pipe, checking the 3-cycle latency.
  task automatic send_one(input logic [6:0] xv, input logic [7:0] yv, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1;
    x        = xv;
    @(negedge clk); check({tag, "_rdy"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 'x;
    @(negedge clk); check({tag, "_ov1"}, 32'(out_valid), 0);
    @(negedge clk); check({tag, "_ov2"}, 32'(out_valid), 0);
    @(negedge clk); check({tag, "_ov3"}, 32'(out_valid), 1);
    check({tag, "_y"}, 32'(y), 32'(yv));
  endtask

  // Drain with a cycle bound; an expired bound shows up as leftovers.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(tag, 32'(exp_q.size()) + 32'(out_valid), 0);
  endtask

  initial begin
    int   ic, oc, acc_cnt;
    logic acc, rdy_ok;
    logic [7:0] y_hold;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;

    // Symmetry halves and boundaries.
    send_one(7'b011_10_01, 8'd119, "sym_pos");
    send_one(7'b011_10_11, 8'd105, "sym_neg");
    send_one(7'b000_00_00, 8'd0,   "zero");
`ifdef SBTM_SAT_EN
    send_one(7'b000_00_11, 8'h00, "under_m1");
    send_one(7'b000_00_10, 8'h00, "under_m2");
`else
    send_one(7'b000_00_11, 8'hFF, "under_m1");
    send_one(7'b000_00_10, 8'hFE, "under_m2");
`endif
    send_one(7'b000_01_11, 8'd7,   "a0_8_m1");
    send_one(7'b111_11_01, 8'd255, "top");
    drain("drain_directed");

    // Streaming: 128 back-to-back operands.
    oc     = out_count;
    rdy_ok = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      x = 7'(i);
      @(negedge clk);
      if (!in_ready) rdy_ok = 1'b0;
      if (i == 2) check("stream_first_early", 32'(out_valid), 0);
      if (i == 3) begin
        check("stream_first_ov", 32'(out_valid), 1);
        check("stream_first_y", 32'(y), 32'(model(7'd0)));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_in_ready", 32'(rdy_ok), 1);
    drain("drain_stream");
    check("stream_count", 32'(out_count - oc), 128);

    // Backpressure: fill while the consumer stalls, then release.
    ic      = in_count;
    oc      = out_count;
    acc_cnt = 0;
    y_hold  = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 7'd40;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (acc) acc_cnt++;
      if (c == 3) begin
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_head_y", 32'(y), 32'(model(7'd40)));
        y_hold = y;
      end
      if (c > 3) check("bp_y_stable", 32'(y), 32'(y_hold));
      @(posedge clk); #1;
      if (acc) x = x + 7'd1;
    end
    check("bp_accepts", 32'(acc_cnt), 3);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) x = x + 7'd1;
    end
    in_valid = 1'b0;
    drain("drain_bp");
    check("bp_no_loss", 32'(out_count - oc), 32'(in_count - ic));

    // Mid-stream reset with two items in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 7'd90;
    @(posedge clk); #1;
    x = 7'd91;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_ov", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_y", 32'(y), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    send_one(7'b011_10_01, 8'd119, "post_rst");
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
